// File: rtl/wasd_key_decoder_if.sv
// Scancode byte stream from the PS/2 byte receiver into the WASD key decoder.
// The receiver drives the master side; the decoder consumes the slave side.
interface wasd_key_decoder_if;
    logic       rx_valid;
    logic [7:0] rx_data;

    modport master (
        output rx_valid,
        output rx_data
    );

    modport slave (
        input  rx_valid,
        input  rx_data
    );
endinterface

// File: rtl/wasd_key_decoder.sv
// Decodes PS/2 set-2 make/break sequences for WASD and the arrow keys into a held-key
// map, and emits rate-limited single-cycle move pulses for the sprite position controller.
module wasd_key_decoder #(
    parameter int MOVE_DIV       = 1_000_000,
    parameter int PREFIX_TIMEOUT = 2_000_000
) (
    input  logic              clk,
    input  logic              rst,
    wasd_key_decoder_if.slave rx,
    output logic              A_signal,
    output logic              D_signal,
    output logic              W_signal,
    output logic              S_signal,
    output logic [3:0]        key_held,
    output logic              move_tick
);

    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int TO_W  = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(PREFIX_TIMEOUT - 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [7:0]        held_q;
    logic [7:0]        held_d;
    logic [TO_W-1:0]   tmo_q;
    logic [TO_W-1:0]   tmo_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [3:0]        key_held_q;
    logic [3:0]        dir_level;
    logic [3:0]        pulse_q;
    logic [3:0]        pulse_d;

    logic              std_hit;
    logic [2:0]        std_idx;
    logic              ext_hit;
    logic [2:0]        ext_idx;

    // Held-map layout: bits 3:0 are the letters A,D,W,S; bits 7:4 the matching arrows.
    always_comb begin
        std_hit = 1'b1;
        std_idx = 3'd0;
        case (rx.rx_data)
            8'h1C:   std_idx = 3'd0;
            8'h23:   std_idx = 3'd1;
            8'h1D:   std_idx = 3'd2;
            8'h1B:   std_idx = 3'd3;
            default: std_hit = 1'b0;
        endcase
    end

    always_comb begin
        ext_hit = 1'b1;
        ext_idx = 3'd4;
        case (rx.rx_data)
            8'h6B:   ext_idx = 3'd4;
            8'h74:   ext_idx = 3'd5;
            8'h75:   ext_idx = 3'd6;
            8'h72:   ext_idx = 3'd7;
            default: ext_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        tmo_d   = tmo_q;
        if (rx.rx_valid) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (rx.rx_data == CODE_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx.rx_data == CODE_BRK) begin
                        state_d = ST_BRK;
                    end else if (std_hit) begin
                        held_d[std_idx] = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx.rx_data == CODE_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx.rx_data == CODE_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        if (ext_hit) begin
                            held_d[ext_idx] = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (std_hit) begin
                        held_d[std_idx] = 1'b0;
                    end
                    state_d = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    if (ext_hit) begin
                        held_d[ext_idx] = 1'b0;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            // A half-received sequence is dropped if the rest never arrives.
            if (tmo_q == TO_LAST) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TO_W'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    assign move_tick = (cnt_q == CNT_LAST);

    // Direction gi opposes gi^1: A<->D and W<->S cancel each other out.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dir
        assign dir_level[gi] = held_q[gi] | held_q[gi + 4];
        assign pulse_d[gi]   = move_tick & key_held_q[gi] & ~key_held_q[gi ^ 1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            held_q     <= '0;
            tmo_q      <= '0;
            cnt_q      <= '0;
            key_held_q <= '0;
            pulse_q    <= '0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            tmo_q      <= tmo_d;
            cnt_q      <= cnt_d;
            key_held_q <= dir_level;
            pulse_q    <= pulse_d;
        end
    end

    assign key_held = key_held_q;
    assign A_signal = pulse_q[0];
    assign D_signal = pulse_q[1];
    assign W_signal = pulse_q[2];
    assign S_signal = pulse_q[3];

endmodule

// File: tb/tb_wasd_key_decoder.sv
// Directed bench for wasd_key_decoder with MOVE_DIV=4, PREFIX_TIMEOUT=8.
module tb_wasd_key_decoder;
    localparam int MOVE_DIV       = 4;
    localparam int PREFIX_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       A_signal;
    logic       D_signal;
    logic       W_signal;
    logic       S_signal;
    logic [3:0] key_held;
    logic       move_tick;

    wasd_key_decoder_if rx_if ();

    int n_cmp = 0;
    int n_bad = 0;

    // pulse monitor totals
    int         a_tot = 0, d_tot = 0, w_tot = 0, s_tot = 0, aw_tot = 0, viol = 0;
    logic       prev_tick = 1'b0;
    logic [3:0] prev_pulse = 4'b0;
    logic [3:0] mon_p;
    int         win_a, win_d, win_w, win_s, win_aw, win_v;

    always #5 clk = ~clk;

    wasd_key_decoder #(
        .MOVE_DIV       (MOVE_DIV),
        .PREFIX_TIMEOUT (PREFIX_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_if),
        .A_signal  (A_signal),
        .D_signal  (D_signal),
        .W_signal  (W_signal),
        .S_signal  (S_signal),
        .key_held  (key_held),
        .move_tick (move_tick)
    );

    always @(negedge clk) begin
        mon_p = {S_signal, W_signal, D_signal, A_signal};
        if (rst === 1'b0) begin
            if ((mon_p & ~{4{prev_tick}}) != 4'b0) viol++;
            if ((mon_p & prev_pulse) != 4'b0) viol++;
            if (A_signal) a_tot++;
            if (D_signal) d_tot++;
            if (W_signal) w_tot++;
            if (S_signal) s_tot++;
            if (A_signal && W_signal) aw_tot++;
        end
        prev_tick  = move_tick;
        prev_pulse = mon_p;
    end

    // Called at posedge+1; returns at posedge+1 two edges later (key_held already updated).
    task automatic send_byte(input logic [7:0] b);
        rx_if.rx_valid = 1'b1;
        rx_if.rx_data  = b;
        @(posedge clk); #1;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic window(input int n);
        int a0, d0, w0, s0, aw0, v0;
        a0 = a_tot; d0 = d_tot; w0 = w_tot; s0 = s_tot; aw0 = aw_tot; v0 = viol;
        repeat (n) @(posedge clk);
        #1;
        win_a = a_tot - a0; win_d = d_tot - d0; win_w = w_tot - w0;
        win_s = s_tot - s0; win_aw = aw_tot - aw0; win_v = viol - v0;
    endtask

    task automatic test_reset();
        logic exp_tick;
        rst = 1'b1;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({A_signal, D_signal, W_signal, S_signal, key_held, move_tick} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {A_signal, D_signal, W_signal, S_signal, key_held, move_tick}, 9'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_tick = ((i % MOVE_DIV) == MOVE_DIV - 1);
            n_cmp++;
            if (move_tick !== exp_tick) begin
                n_bad++;
                $display("FAIL tick_phase[%0d]: got %b expected %b", i, move_tick, exp_tick);
            end
            @(posedge clk); #1;
        end
        $display("test_reset done");
    endtask

    task automatic test_hold_a();
        send_byte(8'h1C);
        n_cmp++;
        if (key_held !== 4'b0001) begin
            n_bad++;
            $display("FAIL hold_a_map: got %b expected %b", key_held, 4'b0001);
        end
        idle(1);
        window(12);
        n_cmp++;
        if ({win_a, win_d, win_w, win_s, win_v} !== {32'd3, 32'd0, 32'd0, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL hold_a_pulses: got a=%0d d=%0d w=%0d s=%0d viol=%0d expected a=3 others 0",
                     win_a, win_d, win_w, win_s, win_v);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        n_cmp++;
        if (key_held !== 4'b0000) begin
            n_bad++;
            $display("FAIL release_a_map: got %b expected %b", key_held, 4'b0000);
        end
        idle(1);
        window(12);
        n_cmp++;
        if (win_a !== 0) begin
            n_bad++;
            $display("FAIL release_a_pulses: got a=%0d expected 0", win_a);
        end
        $display("test_hold_a done");
    endtask

    task automatic test_arrow_up();
        send_byte(8'hE0);
        n_cmp++;
        if (key_held !== 4'b0000) begin
            n_bad++;
            $display("FAIL up_prefix_only: got %b expected %b", key_held, 4'b0000);
        end
        send_byte(8'h75);
        n_cmp++;
        if (key_held !== 4'b0100) begin
            n_bad++;
            $display("FAIL up_make_map: got %b expected %b", key_held, 4'b0100);
        end
        idle(1);
        window(12);
        n_cmp++;
        if ({win_a, win_d, win_w, win_s, win_v} !== {32'd0, 32'd0, 32'd3, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL up_pulses: got a=%0d d=%0d w=%0d s=%0d viol=%0d expected w=3 others 0",
                     win_a, win_d, win_w, win_s, win_v);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        n_cmp++;
        if (key_held !== 4'b0100) begin
            n_bad++;
            $display("FAIL up_partial_break: got %b expected %b", key_held, 4'b0100);
        end
        send_byte(8'h75);
        n_cmp++;
        if (key_held !== 4'b0000) begin
            n_bad++;
            $display("FAIL up_break_map: got %b expected %b", key_held, 4'b0000);
        end
        idle(1);
        window(12);
        n_cmp++;
        if (win_w !== 0) begin
            n_bad++;
            $display("FAIL up_after_release: got w=%0d expected 0", win_w);
        end
        $display("test_arrow_up done");
    endtask

    task automatic test_opposing();
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'h74);
        n_cmp++;
        if (key_held !== 4'b0011) begin
            n_bad++;
            $display("FAIL opp_map: got %b expected %b", key_held, 4'b0011);
        end
        idle(1);
        window(12);
        n_cmp++;
        if ({win_a, win_d} !== {32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL opp_pulses: got a=%0d d=%0d expected a=0 d=0", win_a, win_d);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h74);
        n_cmp++;
        if (key_held !== 4'b0001) begin
            n_bad++;
            $display("FAIL opp_release_map: got %b expected %b", key_held, 4'b0001);
        end
        idle(1);
        window(12);
        n_cmp++;
        if ({win_a, win_d, win_v} !== {32'd3, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL opp_resume: got a=%0d d=%0d viol=%0d expected a=3 d=0 viol=0",
                     win_a, win_d, win_v);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        $display("test_opposing done");
    endtask

    task automatic test_orthogonal();
        send_byte(8'h1D);
        send_byte(8'h1C);
        n_cmp++;
        if (key_held !== 4'b0101) begin
            n_bad++;
            $display("FAIL ortho_map: got %b expected %b", key_held, 4'b0101);
        end
        idle(1);
        window(12);
        n_cmp++;
        if ({win_a, win_w, win_aw, win_d, win_s} !== {32'd3, 32'd3, 32'd3, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL ortho_pulses: got a=%0d w=%0d both=%0d d=%0d s=%0d expected 3 3 3 0 0",
                     win_a, win_w, win_aw, win_d, win_s);
        end
        send_byte(8'hF0);
        send_byte(8'h1D);
        send_byte(8'hF0);
        send_byte(8'h1C);
        n_cmp++;
        if (key_held !== 4'b0000) begin
            n_bad++;
            $display("FAIL ortho_release: got %b expected %b", key_held, 4'b0000);
        end
        $display("test_orthogonal done");
    endtask

    task automatic test_prefix_timeout();
        // 7 idle cycles after E0: sequence still alive, 72 decodes as down.
        send_byte(8'hE0);
        idle(6);
        send_byte(8'h72);
        n_cmp++;
        if (key_held !== 4'b1000) begin
            n_bad++;
            $display("FAIL timeout_not_yet: got %b expected %b", key_held, 4'b1000);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h72);
        n_cmp++;
        if (key_held !== 4'b0000) begin
            n_bad++;
            $display("FAIL timeout_cleanup: got %b expected %b", key_held, 4'b0000);
        end
        // 9 idle cycles after E0: prefix abandoned, 72 is an unmapped plain byte.
        send_byte(8'hE0);
        idle(8);
        send_byte(8'h72);
        n_cmp++;
        if (key_held !== 4'b0000) begin
            n_bad++;
            $display("FAIL timeout_expired: got %b expected %b", key_held, 4'b0000);
        end
        $display("test_prefix_timeout done");
    endtask

    task automatic test_reset_mid_seq();
        send_byte(8'h1C);
        send_byte(8'hE0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (key_held !== 4'b0000) begin
            n_bad++;
            $display("FAIL midrst_cleared: got %b expected %b", key_held, 4'b0000);
        end
        send_byte(8'h1B);
        n_cmp++;
        if (key_held !== 4'b1000) begin
            n_bad++;
            $display("FAIL midrst_fresh_decode: got %b expected %b", key_held, 4'b1000);
        end
        send_byte(8'hF0);
        send_byte(8'h1B);
        n_cmp++;
        if (key_held !== 4'b0000) begin
            n_bad++;
            $display("FAIL midrst_release: got %b expected %b", key_held, 4'b0000);
        end
        $display("test_reset_mid_seq done");
    endtask

    task automatic test_back_to_back();
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        n_cmp++;
        if (key_held !== 4'b0000) begin
            n_bad++;
            $display("FAIL typematic_release: got %b expected %b", key_held, 4'b0000);
        end
        send_byte(8'h29);
        send_byte(8'h23);
        n_cmp++;
        if (key_held !== 4'b0010) begin
            n_bad++;
            $display("FAIL unmapped_then_d: got %b expected %b", key_held, 4'b0010);
        end
        send_byte(8'hE0);
        send_byte(8'hE0);
        send_byte(8'h6B);
        n_cmp++;
        if (key_held !== 4'b0011) begin
            n_bad++;
            $display("FAIL double_prefix_left: got %b expected %b", key_held, 4'b0011);
        end
        send_byte(8'hF0);
        send_byte(8'h23);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6B);
        n_cmp++;
        if (key_held !== 4'b0000) begin
            n_bad++;
            $display("FAIL b2b_release_all: got %b expected %b", key_held, 4'b0000);
        end
        n_cmp++;
        if (viol !== 0) begin
            n_bad++;
            $display("FAIL pulse_protocol: got %0d violations expected 0", viol);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_hold_a();
        test_arrow_up();
        test_opposing();
        test_orthogonal();
        test_prefix_timeout();
        test_reset_mid_seq();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
